axis_sort_engine: RTL and testbench

- Packet-level sorter on the AXI-stream style slave/master signal sets: collects one tlast-terminated packet of up to 2**ADDRESS words and sorts it by insertion on arrival.
- Streams the sorted packet out with olast on the final word.
- Generalises the fixed 16-bit/4-address stream to parametrised width and depth, adds ascending/descending and signed/unsigned modes, and flags oversize packets.
- Sits between the input stream source and downstream consumers of sorted data.

---
 rtl/axis_sort_engine.sv | 178 +++++++++++++++++
 tb/tb_axis_sort_engine.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_sort_engine.sv
// Packet insertion sorter: collects one tlast-terminated packet (up to 2**ADDRESS
// words), keeping storage sorted as each word arrives, then streams it back out.
// Latency: first sorted word valid the cycle after tlast is accepted; drains one word per oready cycle.
// Backpressure: tready is low for the whole output phase; odata/olast hold while oready is low.
//
// Ports:
//   clk, reset            - clock (rising edge) and asynchronous active-low reset
//   tvalid/tready/tlast/tdata - input stream
//   ovalid/oready/olast/odata - sorted output stream
//   sort_desc, sort_signed    - order/compare mode, sampled on the first word of each packet
//   pkt_count             - number of words currently stored
//   trunc                 - sticky: current packet overflowed storage and words were dropped
module axis_sort_engine #(
    parameter int WIDTH   = 16,
    parameter int ADDRESS = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tvalid,
    output logic               tready,
    input  logic               tlast,
    input  logic [WIDTH-1:0]   tdata,
    output logic               ovalid,
    input  logic               oready,
    output logic               olast,
    output logic [WIDTH-1:0]   odata,
    input  logic               sort_desc,
    input  logic               sort_signed,
    output logic [ADDRESS:0]   pkt_count,
    output logic               trunc
);

    localparam int DEPTH = 2 ** ADDRESS;

    typedef enum logic [1:0] {IDLE, LOAD, OUT} state_t;

    state_t             state;
    logic [WIDTH-1:0]   mem     [DEPTH];
    logic [WIDTH-1:0]   mem_nxt [DEPTH];
    logic [ADDRESS:0]   count;
    logic [ADDRESS:0]   count_inc;
    logic [ADDRESS:0]   pos;
    logic [ADDRESS-1:0] rd_idx;
    logic [ADDRESS-1:0] rd_nxt;
    logic               desc_q;
    logic               signed_q;
    logic               desc_eff;
    logic               signed_eff;
    logic               accept;
    logic               first;
    logic               full;
    logic               ins;
    logic [WIDTH-1:0]   head;

    // True when stored entry e must stay ahead of incoming d. Using <= / >= puts
    // new words behind equal ones, which keeps the sort stable.
    function automatic logic goes_before(input logic [WIDTH-1:0] e,
                                         input logic [WIDTH-1:0] d,
                                         input logic dsc,
                                         input logic sgn);
        logic [WIDTH-1:0] ek;
        logic [WIDTH-1:0] dk;
        // Flipping the sign bit maps two's-complement order onto unsigned order.
        ek = e;
        dk = d;
        ek[WIDTH-1] = e[WIDTH-1] ^ sgn;
        dk[WIDTH-1] = d[WIDTH-1] ^ sgn;
        return dsc ? (ek >= dk) : (ek <= dk);
    endfunction

    assign accept    = tvalid & tready;
    assign first     = (count == '0) && !trunc;
    assign full      = (count == (ADDRESS+1)'(DEPTH));
    assign ins       = accept && !full;
    assign count_inc = count + {{ADDRESS{1'b0}}, ins};
    assign rd_nxt    = rd_idx + 1'b1;
    assign pkt_count = count;

    // The first word of a packet is inserted using the live mode inputs, since
    // the latched copy only updates on that same edge.
    assign desc_eff   = first ? sort_desc   : desc_q;
    assign signed_eff = first ? sort_signed : signed_q;

    // Storage is always sorted, so the entries that go before tdata form a prefix.
    always_comb begin
        pos = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (((ADDRESS+1)'(i) < count) && goes_before(mem[i], tdata, desc_eff, signed_eff))
                pos = pos + 1'b1;
        end
    end

    always_comb begin
        mem_nxt[0] = (pos == '0) ? tdata : mem[0];
        for (int i = 1; i < DEPTH; i++) begin
            if ((ADDRESS+1)'(i) < pos)
                mem_nxt[i] = mem[i];
            else if ((ADDRESS+1)'(i) == pos)
                mem_nxt[i] = tdata;
            else
                mem_nxt[i] = mem[i-1];
        end
    end

    // Word presented on the first output beat, including the one inserted on the tlast edge.
    assign head = ins ? mem_nxt[0] : mem[0];

    always_ff @(posedge clk) begin
        if (ins) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= mem_nxt[i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            count    <= '0;
            rd_idx   <= '0;
            tready   <= 1'b0;
            ovalid   <= 1'b0;
            olast    <= 1'b0;
            odata    <= '0;
            trunc    <= 1'b0;
            desc_q   <= 1'b0;
            signed_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state  <= LOAD;
                    tready <= 1'b1;
                end
                LOAD: begin
                    if (accept) begin
                        if (first) begin
                            desc_q   <= sort_desc;
                            signed_q <= sort_signed;
                        end
                        if (full)
                            trunc <= 1'b1;
                        count <= count_inc;
                        if (tlast) begin
                            state  <= OUT;
                            tready <= 1'b0;
                            ovalid <= 1'b1;
                            odata  <= head;
                            olast  <= (count_inc == (ADDRESS+1)'(1));
                        end
                    end
                end
                OUT: begin
                    if (ovalid && oready) begin
                        if (olast) begin
                            state  <= LOAD;
                            tready <= 1'b1;
                            ovalid <= 1'b0;
                            olast  <= 1'b0;
                            odata  <= '0;
                            count  <= '0;
                            rd_idx <= '0;
                            trunc  <= 1'b0;
                        end else begin
                            rd_idx <= rd_nxt;
                            odata  <= mem[rd_nxt];
                            olast  <= ({1'b0, rd_nxt} == (count - 1'b1));
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    tready <= 1'b0;
                    ovalid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_sort_engine.sv
// Bench for axis_sort_engine: directed scenarios plus random packets checked
// against a reference that stably sorts the first 16 words of each packet.
// Runs with default parameters (WIDTH=16, ADDRESS=4).
module tb_axis_sort_engine;

    logic        clk;
    logic        reset;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic [15:0] tdata;
    logic        ovalid;
    logic        oready;
    logic        olast;
    logic [15:0] odata;
    logic        sort_desc;
    logic        sort_signed;
    logic [4:0]  pkt_count;
    logic        trunc;

    int checks = 0;
    int errors = 0;

    logic [15:0] pkt_in  [$];
    logic [15:0] pkt_exp [$];

    axis_sort_engine #(.WIDTH(16), .ADDRESS(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .tvalid      (tvalid),
        .tready      (tready),
        .tlast       (tlast),
        .tdata       (tdata),
        .ovalid      (ovalid),
        .oready      (oready),
        .olast       (olast),
        .odata       (odata),
        .sort_desc   (sort_desc),
        .sort_signed (sort_signed),
        .pkt_count   (pkt_count),
        .trunc       (trunc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int key(input logic [15:0] w, input logic sgn);
        return sgn ? int'($signed(w)) : int'({16'h0, w});
    endfunction

    // Keep the first 16 words, then repeatedly take the smallest (or largest)
    // remaining word, earliest arrival winning ties.
    task automatic build_exp(input logic desc, input logic sgn);
        logic [15:0] tmp [$];
        int best;
        pkt_exp.delete();
        for (int i = 0; i < pkt_in.size() && i < 16; i++)
            tmp.push_back(pkt_in[i]);
        while (tmp.size() > 0) begin
            best = 0;
            for (int j = 1; j < tmp.size(); j++) begin
                if (desc ? (key(tmp[j], sgn) > key(tmp[best], sgn))
                         : (key(tmp[j], sgn) < key(tmp[best], sgn)))
                    best = j;
            end
            pkt_exp.push_back(tmp[best]);
            tmp.delete(best);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives pkt_in as one packet. With scramble set, mode inputs are randomised
    // after the first word to show they are ignored mid-packet.
    task automatic send_pkt(input logic desc, input logic sgn, input bit scramble);
        int n = pkt_in.size();
        int t = 0;
        while (!tready && t < 50) begin
            tick();
            t++;
        end
        chk("tready_wait", tready, 1);
        for (int i = 0; i < n; i++) begin
            sort_desc   = (i == 0 || !scramble) ? desc : 1'($urandom);
            sort_signed = (i == 0 || !scramble) ? sgn  : 1'($urandom);
            tvalid = 1'b1;
            tdata  = pkt_in[i];
            tlast  = (i == n - 1);
            chk("tready_load", tready, 1);
            chk("ovalid_load", ovalid, 0);
            tick();
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
        sort_desc   = 1'($urandom);
        sort_signed = 1'($urandom);
        chk("ovalid_after_tlast", ovalid, 1);
        chk("pkt_count_stored", pkt_count, (n > 16) ? 16 : n);
        chk("trunc_after_load", trunc, n > 16);
        build_exp(desc, sgn);
    endtask

    // mode 0: oready always 1; 1: pattern 1,0,0 repeating; 2: random.
    // stop_at >= 0 returns right after that many handshakes.
    task automatic recv_pkt(input int mode, input int stop_at);
        int k = 0;
        int cyc = 0;
        int n = pkt_exp.size();
        logic [15:0] pd = '0;
        logic pl = 1'b0;
        bit stalled = 0;
        bit exp_trunc = (pkt_in.size() > 16);
        while (k < n && k != stop_at && cyc < 500) begin
            oready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
            if (stalled) begin
                chk("odata_hold", odata, pd);
                chk("olast_hold", olast, pl);
            end
            chk("ovalid_out", ovalid, 1);
            chk("tready_out", tready, 0);
            chk("trunc_out", trunc, exp_trunc);
            if (oready) begin
                chk("odata", odata, pkt_exp[k]);
                chk("olast", olast, k == n - 1);
                k++;
            end
            stalled = !oready;
            pd = odata;
            pl = olast;
            tick();
            cyc++;
        end
        oready = 1'b0;
        if (stop_at < 0) begin
            chk("handshakes", k, n);
            chk("ovalid_done", ovalid, 0);
            chk("tready_done", tready, 1);
            chk("trunc_done", trunc, 0);
            chk("pkt_count_done", pkt_count, 0);
        end
    endtask

    initial begin
        reset = 1'b0;
        tvalid = 1'b0;
        tlast = 1'b0;
        tdata = '0;
        oready = 1'b0;
        sort_desc = 1'b0;
        sort_signed = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tready", tready, 0);
        chk("rst_ovalid", ovalid, 0);
        chk("rst_olast", olast, 0);
        chk("rst_odata", odata, 0);
        chk("rst_trunc", trunc, 0);
        chk("rst_pkt_count", pkt_count, 0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("tready_after_idle", tready, 1);

        // Ascending unsigned with duplicates.
        pkt_in = '{16'd5, 16'd3, 16'd9, 16'd3, 16'd1};
        send_pkt(1'b0, 1'b0, 0);
        chk("exp_model_head", pkt_exp[0], 16'd1);
        recv_pkt(0, -1);

        // Descending signed, then same words ascending unsigned.
        pkt_in = '{16'h0002, 16'hFFFF, 16'h8000, 16'h7FFF};
        send_pkt(1'b1, 1'b1, 1);
        recv_pkt(0, -1);
        pkt_in = '{16'h0002, 16'hFFFF, 16'h8000, 16'h7FFF};
        send_pkt(1'b0, 1'b0, 1);
        recv_pkt(0, -1);

        // Overflow: 18 words, the last two are dropped.
        pkt_in.delete();
        for (int v = 18; v >= 1; v--) pkt_in.push_back(16'(v));
        send_pkt(1'b0, 1'b0, 0);
        recv_pkt(0, -1);

        // Backpressure pattern on a 4-word packet.
        pkt_in.delete();
        for (int i = 0; i < 4; i++) pkt_in.push_back(16'($urandom));
        send_pkt(1'b0, 1'b0, 0);
        recv_pkt(1, -1);

        // Single word, then a back-to-back packet.
        pkt_in = '{16'h00AB};
        send_pkt(1'b0, 1'b0, 0);
        recv_pkt(0, -1);
        pkt_in = '{16'h0010, 16'h0001, 16'h00FF};
        send_pkt(1'b1, 1'b0, 0);
        recv_pkt(0, -1);

        // Reset after two of five output words.
        pkt_in = '{16'd50, 16'd40, 16'd30, 16'd20, 16'd10};
        send_pkt(1'b0, 1'b0, 0);
        recv_pkt(0, 2);
        reset = 1'b0;
        #1;
        chk("midrst_ovalid", ovalid, 0);
        chk("midrst_tready", tready, 0);
        chk("midrst_pkt_count", pkt_count, 0);
        chk("midrst_olast", olast, 0);
        chk("midrst_trunc", trunc, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("release_tready_idle", tready, 0);
        tick();
        chk("release_tready_load", tready, 1);
        pkt_in = '{16'd7, 16'd2, 16'd7, 16'd4};
        send_pkt(1'b0, 1'b0, 0);
        recv_pkt(0, -1);

        // Random packets with random modes, lengths and backpressure.
        for (int p = 0; p < 25; p++) begin
            logic [15:0] mask;
            int len;
            logic d;
            logic s;
            case ($urandom_range(0, 2))
                0:       mask = 16'hFFFF;
                1:       mask = 16'h0007;
                default: mask = 16'h8003;
            endcase
            len = $urandom_range(1, 20);
            d = 1'($urandom);
            s = 1'($urandom);
            pkt_in.delete();
            for (int i = 0; i < len; i++) pkt_in.push_back(16'($urandom) & mask);
            send_pkt(d, s, 1);
            recv_pkt(2, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
